// File: rtl/ultra_range_if.sv
// ultra_range_if: sensor pins, enable and ranging results between the controller and its users
interface ultra_range_if;
    logic       en;
    logic       echo;
    logic       trig;
    logic       busy;
    logic       dist_valid;
    logic       out_of_range;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    modport master (
        input  en, echo,
        output trig, busy, dist_valid, out_of_range, digit0, digit1, digit2, digit3
    );
    modport slave (
        output en, echo,
        input  trig, busy, dist_valid, out_of_range, digit0, digit1, digit2, digit3
    );
endinterface

// File: rtl/ultra_range_ctrl.sv
// ultra_range_ctrl: triggers the ultrasonic sensor, times the echo and counts centimetres directly in BCD
module ultra_range_ctrl #(
    parameter int TRIG_CYCLES   = 500,
    parameter int TICKS_PER_CM  = 2900,
    parameter int MAX_CM        = 400,
    parameter int RISE_TIMEOUT  = 25000,
    parameter int PERIOD_CYCLES = 3000000
) (
    input  logic         clk,
    input  logic         reset,
    ultra_range_if.master bus
);
    localparam int CW = $clog2(TRIG_CYCLES > RISE_TIMEOUT ? TRIG_CYCLES : RISE_TIMEOUT) + 1;
    localparam int PW = $clog2(PERIOD_CYCLES) + 1;
    localparam int SW = $clog2(TICKS_PER_CM) + 1;
    localparam logic [15:0] MAX_BCD = {4'(MAX_CM / 1000 % 10), 4'(MAX_CM / 100 % 10),
                                       4'(MAX_CM / 10 % 10), 4'(MAX_CM % 10)};

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period_q;
    logic [SW-1:0] presc_q, presc_d;
    logic [15:0]   acc_q, acc_d, acc_inc, res_d, digits_q;
    logic          trig_q, oor_q, oor_d;
    logic          rise, fall, tick, sat;

    // sync_q[1] is the synchronised echo; sync_q[2] is its one-cycle-late copy used for edges and counting
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
    // Counting the delayed copy includes the rise-detect cycle and the fall-detect cycle, so the count equals the pin width
    assign tick = (state_q == MEASURE) && sync_q[2] && (presc_q == SW'(TICKS_PER_CM - 1));
    assign sat  = tick && (acc_inc == MAX_BCD);

    // State, counters, synchroniser and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            presc_q  <= '0;
            acc_q    <= '0;
            digits_q <= '0;
            trig_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[1:0], bus.echo};
            cnt_q    <= cnt_d;
            period_q <= (state_d == TRIG && state_q != TRIG) ? '0 : period_q + 1'b1;
            presc_q  <= presc_d;
            acc_q    <= acc_d;
            digits_q <= (state_d == DONE) ? res_d : digits_q;
            oor_q    <= (state_d == DONE) ? oor_d : oor_q;
            trig_q   <= state_d == TRIG;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = bus.en ? TRIG : IDLE;
            TRIG:      if (cnt_q == CW'(TRIG_CYCLES - 1)) state_d = WAIT_RISE;
            WAIT_RISE: if (rise || cnt_q == CW'(RISE_TIMEOUT - 1)) state_d = rise ? MEASURE : DONE;
            MEASURE:   if (sat || fall) state_d = DONE;
            DONE:      state_d = HOLDOFF;
            HOLDOFF:   if (period_q == PW'(PERIOD_CYCLES - 1)) state_d = bus.en ? TRIG : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Ripple-carry BCD increment of the accumulator
    always_comb begin
        logic c;
        acc_inc = acc_q;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_inc[4*i +: 4] = !c ? acc_q[4*i +: 4] : (acc_q[4*i +: 4] == 4'd9 ? 4'd0 : acc_q[4*i +: 4] + 4'd1);
            c = c && (acc_q[4*i +: 4] == 4'd9);
        end
    end

    // Phase counter, cm prescaler, accumulator and the result presented on entry to DONE
    always_comb begin
        cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        presc_d = (state_q == WAIT_RISE) ? '0 : (state_q == MEASURE && sync_q[2]) ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        acc_d   = (state_q == WAIT_RISE) ? '0 : tick ? acc_inc : acc_q;
        res_d   = (state_q == MEASURE) ? acc_d : MAX_BCD;
        oor_d   = (state_q != MEASURE) || sat;
    end

    // Outputs decoded from state and result registers
    always_comb begin
        bus.trig         = trig_q;
        bus.busy         = state_q != IDLE;
        bus.dist_valid   = state_q == DONE;
        bus.out_of_range = oor_q;
        {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = digits_q;
    end
endmodule

// File: tb/tb_ultra_range_ctrl.sv
// tb_ultra_range_ctrl: table, random and corner-sequence checks of the ranging controller
module tb_ultra_range_ctrl;
    localparam int TRIG = 4, TPC = 10, MAXCM = 400, RTO = 50, PER = 6000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0, bad = 0, cyc = 0;

    ultra_range_if bus();

    ultra_range_ctrl #(
        .TRIG_CYCLES(TRIG), .TICKS_PER_CM(TPC), .MAX_CM(MAXCM),
        .RISE_TIMEOUT(RTO), .PERIOD_CYCLES(PER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          delay;
        int          width;
        logic [15:0] bcd;
        logic        oor;
        bit          early;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    function automatic logic [15:0] to_bcd(input int cm);
        return {4'(cm / 1000 % 10), 4'(cm / 100 % 10), 4'(cm / 10 % 10), 4'(cm % 10)};
    endfunction

    task automatic wait_trig(input logic v, input int limit, input string name);
        int n = 0;
        while (bus.trig !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.trig, v);
    endtask

    // One ranging cycle: echo rises delay clocks after trig falls and stays high width clocks
    task automatic measure(input int delay, input int width, output logic [15:0] bcd, output logic oor,
                           output bit early, output int lat, output int ndv);
        early = 0; lat = 99; ndv = 0; bcd = 'x; oor = 1'bx;
        wait_trig(1'b1, PER + 100, "m_trig_rise");
        wait_trig(1'b0, TRIG + 4, "m_trig_fall");
        repeat (delay) @(negedge clk);
        bus.echo = 1'b1;
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            if (bus.dist_valid) begin
                ndv++;
                if (!early) begin early = 1; bcd = digits(); oor = bus.out_of_range; end
            end
        end
        bus.echo = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.dist_valid) begin
                ndv++;
                if (!early && lat == 99) begin lat = i; bcd = digits(); oor = bus.out_of_range; end
            end
        end
    endtask

    vec_t        vecs[6];
    logic [15:0] bcd;
    logic        oor;
    bit          early;
    int          lat, ndv, n, t0, tf, w, d, cm, trig_hi;

    initial begin
        #1_500_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{20, 1235, 16'h0123, 1'b0, 1'b0};
        vecs[1] = '{20, 9,    16'h0000, 1'b0, 1'b0};
        vecs[2] = '{20, 4100, 16'h0400, 1'b1, 1'b1};
        vecs[3] = '{15, 1000, 16'h0100, 1'b0, 1'b0};
        vecs[4] = '{25, 990,  16'h0099, 1'b0, 1'b0};
        vecs[5] = '{10, 1090, 16'h0109, 1'b0, 1'b0};

        bus.en = 1'b0; bus.echo = 1'b0; reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", bus.trig, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_dv", bus.dist_valid, 0);
        check("rst_oor", bus.out_of_range, 0);
        check("rst_digits", digits(), 0);
        reset = 1'b1;
        bus.en = 1'b1;

        // Echo never rises: timeout reports the ceiling as out of range
        wait_trig(1'b1, 10, "first_trig");
        t0 = cyc;
        n = 0;
        while (bus.trig && n < 20) begin n++; @(negedge clk); end
        check("trig_width", n, TRIG);
        tf = cyc;
        n = 0;
        while (!bus.dist_valid && n < 100) begin n++; @(negedge clk); end
        check("to_dv", bus.dist_valid, 1);
        check("to_delay", cyc - tf, RTO);
        check("to_digits", digits(), 16'h0400);
        check("to_oor", bus.out_of_range, 1);
        @(negedge clk);
        check("to_dv_one", bus.dist_valid, 0);
        repeat (100) @(negedge clk);
        check("to_hold", digits(), 16'h0400);
        wait_trig(1'b1, PER + 100, "period_trig");
        check("period", cyc - t0, PER);

        // Directed table
        for (int k = 0; k < 6; k++) begin
            measure(vecs[k].delay, vecs[k].width, bcd, oor, early, lat, ndv);
            check($sformatf("vec%0d_bcd", k), bcd, vecs[k].bcd);
            check($sformatf("vec%0d_oor", k), oor, vecs[k].oor);
            check($sformatf("vec%0d_early", k), early, vecs[k].early);
            check($sformatf("vec%0d_ndv", k), ndv, 1);
            if (!vecs[k].early) check($sformatf("vec%0d_lat", k), lat <= 5, 1);
        end

        // Random widths against the arithmetic model
        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(4200, 1);
            d = $urandom_range(40, 0);
            cm = w / TPC;
            measure(d, w, bcd, oor, early, lat, ndv);
            check($sformatf("rnd%0d_w%0d_bcd", k, w), bcd, to_bcd(cm >= MAXCM ? MAXCM : cm));
            check($sformatf("rnd%0d_w%0d_oor", k, w), oor, cm >= MAXCM);
            check($sformatf("rnd%0d_w%0d_early", k, w), early, w > MAXCM * TPC);
            check($sformatf("rnd%0d_w%0d_ndv", k, w), ndv, 1);
        end

        // en dropped mid-measurement: result reported, then IDLE at period end
        wait_trig(1'b1, PER + 100, "ed_trig");
        t0 = cyc;
        wait_trig(1'b0, TRIG + 4, "ed_trig_fall");
        repeat (10) @(negedge clk);
        bus.echo = 1'b1;
        repeat (100) @(negedge clk);
        bus.en = 1'b0;
        repeat (400) @(negedge clk);
        bus.echo = 1'b0;
        n = 0;
        while (!bus.dist_valid && n < 10) begin n++; @(negedge clk); end
        check("ed_dv", bus.dist_valid, 1);
        check("ed_digits", digits(), 16'h0050);
        check("ed_oor", bus.out_of_range, 0);
        trig_hi = 0;
        n = 0;
        while (bus.busy && n < PER) begin
            n++;
            @(negedge clk);
            if (bus.trig) trig_hi++;
        end
        check("ed_idle_time", cyc - t0, PER);
        repeat (200) begin
            @(negedge clk);
            if (bus.trig) trig_hi++;
        end
        check("ed_no_trig", trig_hi, 0);
        check("ed_busy", bus.busy, 0);

        // Async reset in TRIG
        bus.en = 1'b1;
        wait_trig(1'b1, 10, "r1_trig");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("r1_trig0", bus.trig, 0);
        check("r1_busy", bus.busy, 0);
        check("r1_digits", digits(), 0);
        check("r1_oor", bus.out_of_range, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_trig(1'b1, 10, "r1_restart");
        n = 0;
        while (bus.trig && n < 20) begin n++; @(negedge clk); end
        check("r1_trig_width", n, TRIG);

        // Async reset in MEASURE discards the partial count
        repeat (5) @(negedge clk);
        bus.echo = 1'b1;
        repeat (300) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("r2_trig0", bus.trig, 0);
        check("r2_busy", bus.busy, 0);
        check("r2_dv", bus.dist_valid, 0);
        check("r2_oor", bus.out_of_range, 0);
        bus.echo = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        measure(20, 77, bcd, oor, early, lat, ndv);
        check("r2_bcd", bcd, 16'h0007);
        check("r2_oor_after", oor, 0);
        check("r2_ndv", ndv, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
